// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept, consume;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          out_data_d = in_data;
          out_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (accept && consume) begin
          out_data_d = in_data;
          out_ctrl_d = in_ctrl;
        end else if (consume) begin
          state_d = EMPTY;
        end else if (accept) begin
          // Downstream stalled: park the new word behind the output entry.
          state_d     = TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end
      end
      TWO: begin
        if (consume) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
          out_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush)
      state_d = EMPTY;
    if (state_d == EMPTY)
      out_ctrl_d = '0;
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: skid storage is reset too so out_* never exposes X after a TWO->ONE move.
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
`else
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    unique case (state_q)
      EMPTY, ONE: begin
        if (accept) begin
          state_d    = ONE;
          out_data_d = in_data;
          out_ctrl_d = in_ctrl;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush)
      state_d = EMPTY;
    if (state_d == EMPTY)
      out_ctrl_d = '0;
  end

  assign in_ready  = !out_valid || out_ready;
  assign occupancy = {1'b0, out_valid};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue-based reference model plus directed literal checks.
// Works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush, in_valid, out_ready, stat_clr;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy),
    .stat_clr  (stat_clr),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of held words with capacity CAP.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } word_t;

  word_t            q[$];
  logic [CNT_W-1:0] m_stall;
  bit               m_rdy_reg;

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return m_rdy_reg;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_stall   = '0;
      m_rdy_reg = 1'b1;
    end else begin
      bit acc, con;
      acc = in_valid && m_in_ready();
      con = (q.size() > 0) && out_ready;
      if (stat_clr)
        m_stall = '0;
      else if ((q.size() > 0) && !out_ready && (m_stall < (2**CNT_W - 1)))
        m_stall = m_stall + 1'b1;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back('{data: in_data, ctrl: in_ctrl});
      end
      m_rdy_reg = (q.size() < CAP);
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    bit mv;
    mv = (q.size() > 0);
    check("out_valid", 64'(out_valid), 64'(mv));
    if (mv) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
    end else begin
      check("out_ctrl_bubble", 64'(out_ctrl), 64'(0));
    end
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(m_in_ready()));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vpat, rpat;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
    in_data = '0; in_ctrl = '0;
    vpat = 32'hB6D5_9A3F;
    rpat = 32'h9E37_79B9;

    // Reset state
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    step();
    check("no_accept_in_reset", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    step();

    // Streaming at full throughput
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h01; step();
    check("stream_0x11", 64'(out_data), 64'h11);
    in_data = 32'h22; in_ctrl = 8'h02; step();
    check("stream_0x22", 64'(out_data), 64'h22);
    in_data = 32'h33; in_ctrl = 8'h03; step();
    check("stream_0x33", 64'(out_data), 64'h33);
    in_valid = 1'b0; step();
    check("stream_drained", 64'(out_valid), 64'd0);
    check("stream_stall", 64'(stall_cnt), 64'd0);

    // Hold under back-pressure, count stalls, then clear
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAA; in_ctrl = 8'hFF; step();
    in_valid = 1'b0;
    repeat (5) step();
    check("hold_data", 64'(out_data), 64'hAA);
    check("hold_ctrl", 64'(out_ctrl), 64'hFF);
    check("hold_stall5", 64'(stall_cnt), 64'd5);
`ifdef PIPE_STAGE_SKID_EN
    check("hold_in_ready_skid", 64'(in_ready), 64'd1);
`else
    check("hold_in_ready_comb0", 64'(in_ready), 64'd0);
    out_ready = 1'b1; #1;
    check("in_ready_comb1", 64'(in_ready), 64'd1);
    out_ready = 1'b0; #1;
`endif
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check("stat_clr", 64'(stall_cnt), 64'd0);

    // Saturation, then simultaneous flush + stat_clr
    repeat (20) step();
    check("stall_saturate", 64'(stall_cnt), 64'hF);
    flush = 1'b1; stat_clr = 1'b1; step(); flush = 1'b0; stat_clr = 1'b0;
    check("flush_clr_valid", 64'(out_valid), 64'd0);
    check("flush_clr_stall", 64'(stall_cnt), 64'd0);

    // Flush while ONE discards a same-cycle offered word
    in_valid = 1'b1; in_data = 32'h5A; in_ctrl = 8'h0C; step();
    check("pre_flush_ctrl", 64'(out_ctrl), 64'h0C);
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hBB; in_ctrl = 8'h77; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ctrl", 64'(out_ctrl), 64'd0);
    check("flush_occ", 64'(occupancy), 64'd0);
    repeat (3) step();
    check("flush_bb_gone", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_SKID_EN
    // Skid entry fills and drains in order
    in_valid = 1'b1; in_data = 32'h01; in_ctrl = 8'h11; step();
    out_ready = 1'b0; in_data = 32'h02; in_ctrl = 8'h22; step();
    in_valid = 1'b0;
    check("skid_occ2", 64'(occupancy), 64'd2);
    check("skid_in_ready0", 64'(in_ready), 64'd0);
    check("skid_head", 64'(out_data), 64'h01);
    out_ready = 1'b1; step();
    check("skid_second", 64'(out_data), 64'h02);
    check("skid_in_ready1", 64'(in_ready), 64'd1);
    step();
    check("skid_empty", 64'(out_valid), 64'd0);
`endif

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h3C; step();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ctrl", 64'(out_ctrl), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'h99; in_ctrl = 8'h05; step();
    in_valid = 1'b0;
    check("post_rst_data", 64'(out_data), 64'h99);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; step();

    // Mixed valid/ready pattern, checked cycle by cycle against the model
    for (int i = 0; i < 40; i++) begin
      in_valid  = vpat[i % 32];
      out_ready = rpat[(i * 7) % 32];
      in_data   = 32'h1000 + 32'(i);
      in_ctrl   = 8'(i) ^ 8'h5A;
      flush     = (i == 23);
      stat_clr  = (i == 31);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("final_empty", 64'(out_valid), 64'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
